q_update: RTL and testbench
===========================

Q_UPDATE -- requirements
Module: q_update

Interface
REQ-001 SHALL have parameter GOAL_STATE, default 36: terminal maze cell (1..36).
REQ-002 SHALL have parameter ALPHA_SHIFT, default 2: learning rate alpha = 2^-ALPHA_SHIFT.
REQ-003 SHALL have parameter GAMMA_SHIFT, default 3: discount gamma = 1 - 2^-GAMMA_SHIFT.
REQ-004 SHALL have ports, in this order:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request one Q update.
- state  in  6  cell before the move (1..36).
- action  in  4  move taken: 0 down +6, 1 right +1, 2 up -6, 3 left -1.
- next_state  in  6  cell produced by the transition stage.
- clear  in  1  zero the whole Q table.
- rd_state  in  6  read-port cell index.
- rd_q  out  4x32 signed  Q[rd_state][0..3], combinational from table.
- busy  out  1  update in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done: request rejected.
- goal_hit  out  1  valid with done: next_state == GOAL_STATE.

Function
REQ-005 Q table SHALL be 37x4 entries, signed Q16.16 32-bit; index 0 unused and held at zero.
REQ-006 start SHALL be accepted only in IDLE with clear low; state, action and next_state SHALL be latched on acceptance.
REQ-007 start while busy SHALL be ignored; clear in the same cycle as start SHALL win, and start is dropped.
REQ-008 FSM states: IDLE -> MAX (4 cycles, scans Q[next_state][0..3]) -> CALC (1) -> WRITE (1) -> DONE (1) -> IDLE.
REQ-009 busy SHALL be high in MAX, CALC, WRITE and DONE; done SHALL be high only in DONE.
REQ-010 If start is accepted at edge N, done SHALL be high in the cycle after edge N+6.
REQ-011 The written value SHALL be visible on rd_q in the same cycle as done.
REQ-012 Reward r:
- +100.0 (0x0064_0000) if next_state == GOAL_STATE.
- otherwise -5.0 (0xFFFB_0000) if next_state == state (wall or blocked bump).
- otherwise -1.0 (0xFFFF_0000).
REQ-013 maxQ SHALL be the signed maximum of the four Q[next_state] entries; on ties, the lowest action index wins.
REQ-014 target SHALL be r at the goal (terminal); otherwise r + maxQ - (maxQ >>> GAMMA_SHIFT).
REQ-015 delta = target - Q[state][action]; new = Q[state][action] + (delta >>> ALPHA_SHIFT).
REQ-016 All arithmetic SHALL use 34-bit signed intermediates; the final result SHALL saturate to 0x7FFF_FFFF / 0x8000_0000.
REQ-017 Invalid request (state 0 or >36, next_state 0 or >36, action >3): FSM SHALL still pass through DONE at the same latency, err = 1, and no table write.
REQ-018 goal_hit SHALL be computed from the latched next_state even when err = 1.
REQ-019 clear in IDLE SHALL zero all entries at the next edge; clear outside IDLE SHALL be ignored.
REQ-020 rd_state outside 1..36 SHALL return all-zero rd_q.

Reset
REQ-021 rst SHALL force IDLE, busy/done/err/goal_hit = 0, all Q entries = 0, and latched inputs = 0.
REQ-022 rst mid-update SHALL abort with no partial write; the first start after release SHALL behave as from power-up.

Structure
REQ-023 Package q_pkg SHALL hold:
- NUM_STATES = 37, NUM_ACTIONS = 4.
- q_t (signed 32-bit), state_t (6-bit).
- action enum ACT_DOWN/ACT_RIGHT/ACT_UP/ACT_LEFT.
- reward constants R_GOAL, R_WALL, R_STEP.
REQ-024 The saturating Q16.16 add/sub SHALL be a single sub-module, q_sat_add, instantiated for target and new-value computation.

Verification
REQ-025 After reset, start s=35, a=1, ns=36 -> done after 7 edges, goal_hit=1, err=0, Q[35][1] = 0x0019_0000 (25.0).
REQ-026 Empty table, s=1, a=2, ns=1 -> r=-5.0, Q[1][2] = 0xFFFE_C000 (-1.25), goal_hit=0.
REQ-027 Chained updates: s=35, a=1, ns=36 (Q[35][1]=25.0), then s=34, a=1, ns=35 -> maxQ=25.0, target=20.875, Q[34][1] = 0x0005_3800.
REQ-028 Sequencing and priority:
- start pulsed again during MAX -> ignored; exactly one done.
- clear and start in the same IDLE cycle -> table zeroed, no busy.
REQ-029 Invalid requests:
- a=4 -> done with err=1, rd_q for every state unchanged.
- s=0 -> done with err=1, table unchanged.
REQ-030 rst asserted during CALC -> busy=0 immediately, all rd_q = 0, no done pulse.

Source files
------------

// File: rtl/q_pkg.sv
// Shared types and constants for the maze Q-learning update engine.
// Q values are signed Q16.16; arithmetic is carried in 34-bit signed intermediates.
package q_pkg;

    localparam int NUM_STATES  = 37;
    localparam int NUM_ACTIONS = 4;

    typedef logic signed [31:0] q_t;
    typedef logic signed [33:0] wide_t;
    typedef logic [5:0]         state_t;

    typedef enum logic [1:0] {
        ACT_DOWN  = 2'd0,
        ACT_RIGHT = 2'd1,
        ACT_UP    = 2'd2,
        ACT_LEFT  = 2'd3
    } action_t;

    localparam q_t R_GOAL = 32'sh0064_0000;
    localparam q_t R_WALL = 32'shFFFB_0000;
    localparam q_t R_STEP = 32'shFFFF_0000;

    // Cell 0 is unused and held at zero; real cells are 1..NUM_STATES-1.
    function automatic logic state_ok(input state_t s);
        return (s != 6'd0) && (s < 6'(NUM_STATES));
    endfunction

endpackage

// File: rtl/q_sat_add.sv
// Saturating Q16.16 add/subtract: wide operands in, clamped 32-bit result out.
module q_sat_add
    import q_pkg::*;
(
    input  wide_t a,
    input  wide_t b,
    input  logic  sub,
    output q_t    sum
);

    localparam wide_t Q_MAX = 34'sh0_7FFF_FFFF;
    localparam wide_t Q_MIN = 34'sh3_8000_0000;

    wide_t raw;

    always_comb begin
        raw = sub ? (a - b) : (a + b);
        if (raw > Q_MAX) begin
            sum = 32'sh7FFF_FFFF;
        end else if (raw < Q_MIN) begin
            sum = 32'sh8000_0000;
        end else begin
            sum = q_t'(raw[31:0]);
        end
    end

endmodule

// File: rtl/q_update.sv
// Single-entry Q-learning update: scans max Q of the next cell, forms the
// discounted target, and writes Q[state][action] += (target - Q) >>> ALPHA_SHIFT.
module q_update
    import q_pkg::*;
#(
    parameter int GOAL_STATE  = 36,
    parameter int ALPHA_SHIFT = 2,
    parameter int GAMMA_SHIFT = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [5:0]                 state,
    input  logic [3:0]                 action,
    input  logic [5:0]                 next_state,
    input  logic                       clear,
    input  logic [5:0]                 rd_state,
    output q_t   [NUM_ACTIONS-1:0]     rd_q,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic                       goal_hit
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_MAX   = 3'd1;
    localparam logic [2:0] S_CALC  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0] fsm;
    logic [1:0] scan_idx;
    state_t     s_r;
    state_t     ns_r;
    logic [3:0] a_r;
    logic       err_r;
    q_t         max_r;
    q_t         target_r;
    q_t         q_tab [NUM_STATES][NUM_ACTIONS];

    logic  goal_w;
    q_t    scan_q;
    q_t    cur_q;
    q_t    reward;
    wide_t disc;
    wide_t delta;
    q_t    target_w;
    q_t    new_w;

    assign goal_w = (ns_r == 6'(GOAL_STATE));
    assign scan_q = state_ok(ns_r) ? q_tab[ns_r][scan_idx] : '0;
    assign cur_q  = err_r ? '0 : q_tab[s_r][a_r[1:0]];
    assign reward = goal_w ? R_GOAL : ((ns_r == s_r) ? R_WALL : R_STEP);

    // gamma * maxQ with gamma = 1 - 2^-GAMMA_SHIFT, done as a shift-subtract.
    assign disc  = wide_t'(max_r) - (wide_t'(max_r) >>> GAMMA_SHIFT);
    assign delta = wide_t'(target_r) - wide_t'(cur_q);

    q_sat_add u_target (
        .a   (wide_t'(reward)),
        .b   (goal_w ? '0 : disc),
        .sub (1'b0),
        .sum (target_w)
    );

    q_sat_add u_new (
        .a   (wide_t'(cur_q)),
        .b   (delta >>> ALPHA_SHIFT),
        .sub (1'b0),
        .sum (new_w)
    );

    always_comb begin
        for (int i = 0; i < NUM_ACTIONS; i++) begin
            rd_q[i] = state_ok(rd_state) ? q_tab[rd_state][i] : '0;
        end
    end

    assign busy     = (fsm != S_IDLE);
    assign done     = (fsm == S_DONE);
    assign err      = done & err_r;
    assign goal_hit = done & goal_w;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm      <= S_IDLE;
            scan_idx <= '0;
            s_r      <= '0;
            ns_r     <= '0;
            a_r      <= '0;
            err_r    <= 1'b0;
            max_r    <= '0;
            target_r <= '0;
            for (int s = 0; s < NUM_STATES; s++) begin
                for (int a = 0; a < NUM_ACTIONS; a++) begin
                    q_tab[s][a] <= '0;
                end
            end
        end else begin
            case (fsm)
                S_IDLE: begin
                    if (clear) begin
                        for (int s = 0; s < NUM_STATES; s++) begin
                            for (int a = 0; a < NUM_ACTIONS; a++) begin
                                q_tab[s][a] <= '0;
                            end
                        end
                    end else if (start) begin
                        s_r      <= state;
                        ns_r     <= next_state;
                        a_r      <= action;
                        err_r    <= !(state_ok(state) && state_ok(next_state) && (action < 4'd4));
                        scan_idx <= '0;
                        fsm      <= S_MAX;
                    end
                end
                S_MAX: begin
                    // Strict compare keeps the lowest action index on ties.
                    if ((scan_idx == 2'd0) || (scan_q > max_r)) begin
                        max_r <= scan_q;
                    end
                    scan_idx <= scan_idx + 2'd1;
                    if (scan_idx == 2'd3) begin
                        fsm <= S_CALC;
                    end
                end
                S_CALC: begin
                    target_r <= target_w;
                    fsm      <= S_WRITE;
                end
                S_WRITE: begin
                    if (!err_r) begin
                        q_tab[s_r][a_r[1:0]] <= new_w;
                    end
                    fsm <= S_DONE;
                end
                S_DONE: begin
                    fsm <= S_IDLE;
                end
                default: begin
                    fsm <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_q_update.sv
// Directed bench for q_update: vector table of single updates with hand-computed
// results, then sequencing, clear priority and mid-update reset scenarios.
module tb_q_update;
    import q_pkg::*;

    logic                   clk;
    logic                   rst;
    logic                   start;
    logic [5:0]             state;
    logic [3:0]             action;
    logic [5:0]             next_state;
    logic                   clear;
    logic [5:0]             rd_state;
    q_t   [NUM_ACTIONS-1:0] rd_q;
    logic                   busy;
    logic                   done;
    logic                   err;
    logic                   goal_hit;

    int checks = 0;
    int errors = 0;

    logic [3:0][31:0] mdl [64];

    typedef struct {
        logic [5:0]  s;
        logic [3:0]  a;
        logic [5:0]  ns;
        logic        e;
        logic        g;
        logic [31:0] q;
    } vec_t;

    vec_t vecs [12];

    q_update dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .state      (state),
        .action     (action),
        .next_state (next_state),
        .clear      (clear),
        .rd_state   (rd_state),
        .rd_q       (rd_q),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .goal_hit   (goal_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic scan_table(input string name);
        for (int r = 0; r <= 40; r++) begin
            rd_state = 6'(r);
            #1;
            chk($sformatf("%s row %0d", name, r), rd_q, mdl[r]);
        end
    endtask

    task automatic zero_model();
        for (int r = 0; r < 64; r++) mdl[r] = '0;
    endtask

    // Issue one request; report edges from acceptance to done and the done-cycle outputs.
    task automatic do_req(input logic [5:0] s, input logic [3:0] a, input logic [5:0] ns,
                          output int lat, output logic e, output logic g, output logic [31:0] qv);
        lat = -1; e = 1'b0; g = 1'b0; qv = '0;
        @(negedge clk);
        state = s; action = a; next_state = ns; rd_state = s; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = c; e = err; g = goal_hit; qv = rd_q[a[1:0]];
                break;
            end
        end
        @(posedge clk);
        #1;
        chk("single done pulse", {done, busy}, 2'b00);
    endtask

    int          lat;
    logic        e, g;
    logic [31:0] qv;
    int          n_done;

    initial begin
        vecs[0]  = '{6'd35, 4'd1, 6'd36, 1'b0, 1'b1, 32'h0019_0000};
        vecs[1]  = '{6'd34, 4'd1, 6'd35, 1'b0, 1'b0, 32'h0005_3800};
        vecs[2]  = '{6'd1,  4'd2, 6'd1,  1'b0, 1'b0, 32'hFFFE_C000};
        vecs[3]  = '{6'd1,  4'd2, 6'd1,  1'b0, 1'b0, 32'hFFFD_D000};
        vecs[4]  = '{6'd35, 4'd1, 6'd36, 1'b0, 1'b1, 32'h002B_C000};
        vecs[5]  = '{6'd2,  4'd1, 6'd3,  1'b0, 1'b0, 32'hFFFF_C000};
        vecs[6]  = '{6'd36, 4'd0, 6'd36, 1'b0, 1'b1, 32'h0019_0000};
        vecs[7]  = '{6'd5,  4'd4, 6'd6,  1'b1, 1'b0, 32'h0};
        vecs[8]  = '{6'd0,  4'd1, 6'd1,  1'b1, 1'b0, 32'h0};
        vecs[9]  = '{6'd1,  4'd0, 6'd37, 1'b1, 1'b0, 32'h0};
        vecs[10] = '{6'd36, 4'd3, 6'd0,  1'b1, 1'b0, 32'h0};
        vecs[11] = '{6'd40, 4'd1, 6'd36, 1'b1, 1'b1, 32'h0};

        rst = 1'b1; start = 1'b0; clear = 1'b0;
        state = '0; action = '0; next_state = '0; rd_state = '0;
        zero_model();
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        #1;
        chk("reset outputs", {busy, done, err, goal_hit}, 4'b0000);
        scan_table("reset table");

        for (int i = 0; i < 12; i++) begin
            do_req(vecs[i].s, vecs[i].a, vecs[i].ns, lat, e, g, qv);
            chk($sformatf("vec%0d latency", i), lat, 6);
            chk($sformatf("vec%0d err", i), e, vecs[i].e);
            chk($sformatf("vec%0d goal_hit", i), g, vecs[i].g);
            if (!vecs[i].e) begin
                chk($sformatf("vec%0d q", i), qv, vecs[i].q);
                mdl[vecs[i].s][vecs[i].a[1:0]] = vecs[i].q;
            end else begin
                scan_table($sformatf("vec%0d unchanged", i));
            end
        end
        scan_table("after vectors");

        // Second start during MAX must be dropped.
        @(negedge clk);
        state = 6'd10; action = 4'd0; next_state = 6'd16; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        state = 6'd11; next_state = 6'd17; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n_done = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk);
            #1;
            if (done) n_done++;
        end
        chk("restart during MAX done count", n_done, 1);
        mdl[10][0] = 32'hFFFF_C000;
        scan_table("restart during MAX");

        // clear beats start in the same IDLE cycle.
        @(negedge clk);
        state = 6'd20; action = 4'd1; next_state = 6'd21; start = 1'b1; clear = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; clear = 1'b0;
        chk("clear+start busy", busy, 1'b0);
        @(posedge clk);
        #1;
        chk("clear+start still idle", {busy, done}, 2'b00);
        zero_model();
        scan_table("after clear");

        do_req(6'd5, 4'd3, 6'd4, lat, e, g, qv);
        chk("pre-reset q", qv, 32'hFFFF_C000);
        mdl[5][3] = 32'hFFFF_C000;

        // Reset while in CALC aborts the update and wipes the table.
        @(negedge clk);
        state = 6'd35; action = 4'd1; next_state = 6'd36; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("reset in CALC outputs", {busy, done, err, goal_hit}, 4'b0000);
        zero_model();
        scan_table("reset in CALC");
        @(negedge clk) rst = 1'b0;
        n_done = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (done) n_done++;
        end
        chk("no done after abort", n_done, 0);

        do_req(6'd35, 4'd1, 6'd36, lat, e, g, qv);
        chk("post-reset latency", lat, 6);
        chk("post-reset goal_hit", g, 1'b1);
        chk("post-reset q", qv, 32'h0019_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
